// File: rtl/shifter_pkg.sv
// Shared types for the shifter arbiter: ARM shift-type encoding and sequencer states.
package shifter_pkg;

  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/shifter_arbiter_if.sv
// Request/response bundle between two shift requesters and the shared barrel-shift unit.
interface shifter_arbiter_if;

  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_type;
  logic [9:0]  req_amt;
  logic [63:0] req_data;
  logic [1:0]  req_cin;
  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_carry;
  logic        rsp_ready;
  logic        busy;

  modport slave (
    input  req_valid, req_type, req_amt, req_data, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, busy
  );

  modport master (
    output req_valid, req_type, req_amt, req_data, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, busy
  );

endinterface

// File: rtl/shift_core.sv
// Combinational ARM barrel shifter with shifter carry-out.
// Build option SHIFTER_ARB_RRX_EN: ROR #0 acts as RRX instead of passing the operand through.
module shift_core
  import shifter_pkg::*;
(
  input  shift_type_e        i_type,
  input  logic [AMT_W-1:0]   i_amt,
  input  logic [DATA_W-1:0]  i_data,
  input  logic               i_cin,
  output logic [DATA_W-1:0]  o_result,
  output logic               o_carry
);

  logic [AMT_W-1:0] w_amt_m1;
  logic [AMT_W-1:0] w_amt_neg;
  logic             w_amt_nz;

  // For n in 1..31, 32-n fits in 5 bits and is the LSL carry index / ROR left-shift amount.
  assign w_amt_m1  = i_amt - 5'd1;
  assign w_amt_neg = 5'd0 - i_amt;
  assign w_amt_nz  = (i_amt != '0);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    o_result = i_data;
    o_carry  = i_cin;
    case (i_type)
      SH_LSL: begin
        if (w_amt_nz) begin
          o_result = i_data << i_amt;
          o_carry  = i_data[w_amt_neg];
        end
      end
      SH_LSR: begin
        if (w_amt_nz) begin
          o_result = i_data >> i_amt;
          o_carry  = i_data[w_amt_m1];
        end else begin
          o_result = '0;
          o_carry  = i_data[DATA_W-1];
        end
      end
      SH_ASR: begin
        if (w_amt_nz) begin
          o_result = $signed(i_data) >>> i_amt;
          o_carry  = i_data[w_amt_m1];
        end else begin
          o_result = {DATA_W{i_data[DATA_W-1]}};
          o_carry  = i_data[DATA_W-1];
        end
      end
      SH_ROR: begin
        if (w_amt_nz) begin
          o_result = (i_data >> i_amt) | (i_data << w_amt_neg);
          o_carry  = o_result[DATA_W-1];
        end else begin
`ifdef SHIFTER_ARB_RRX_EN
          o_result = {i_cin, i_data[DATA_W-1:1]};
          o_carry  = i_data[0];
`else
          o_result = i_data;
          o_carry  = i_cin;
`endif
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/shifter_arbiter.sv
// Arbitrates two requesters onto one shift_core through an IDLE -> BUSY -> DONE sequence.
// ROR #0 behaviour follows the SHIFTER_ARB_RRX_EN build option inside shift_core.
module shifter_arbiter
  import shifter_pkg::*;
#(
  parameter bit PRIO_FIXED = 1'b0
) (
  input logic              clk,
  input logic              reset,
  shifter_arbiter_if.slave bus
);

  state_e            r_state;
  state_e            w_next;
  logic              r_last_grant;
  logic              w_grant;
  logic              w_xfer;
  logic [1:0]        w_ready;

  shift_type_e       r_type;
  logic [AMT_W-1:0]  r_amt;
  logic [DATA_W-1:0] r_data;
  logic              r_cin;
  logic              r_id;

  logic              r_rsp_id;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_carry;

  logic [DATA_W-1:0] w_sh_result;
  logic              w_sh_carry;

  // On a tie round-robin favours the requester not granted last.
  always_comb begin
    if (&bus.req_valid) w_grant = PRIO_FIXED ? 1'b0 : ~r_last_grant;
    else                w_grant = bus.req_valid[1];
  end

  always_comb begin
    w_next  = r_state;
    w_ready = '0;
    w_xfer  = 1'b0;
    case (r_state)
      IDLE: begin
        if (reset && (|bus.req_valid)) begin
          w_ready[w_grant] = 1'b1;
          w_xfer           = 1'b1;
          w_next           = BUSY;
        end
      end
      BUSY:    w_next = DONE;
      DONE:    if (bus.rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= 1'b1;
      r_type       <= SH_LSL;
      r_amt        <= '0;
      r_data       <= '0;
      r_cin        <= 1'b0;
      r_id         <= 1'b0;
    end else if (w_xfer) begin
      r_last_grant <= w_grant;
      r_id         <= w_grant;
      r_type       <= shift_type_e'(w_grant ? bus.req_type[3:2] : bus.req_type[1:0]);
      r_amt        <= w_grant ? bus.req_amt[9:5]    : bus.req_amt[4:0];
      r_data       <= w_grant ? bus.req_data[63:32] : bus.req_data[31:0];
      r_cin        <= w_grant ? bus.req_cin[1]      : bus.req_cin[0];
    end
  end

  shift_core u_shift_core (
    .i_type   (r_type),
    .i_amt    (r_amt),
    .i_data   (r_data),
    .i_cin    (r_cin),
    .o_result (w_sh_result),
    .o_carry  (w_sh_carry)
  );

  // Response registers load only in BUSY, so they hold steady through DONE backpressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_carry <= 1'b0;
    end else if (r_state == BUSY) begin
      r_rsp_id    <= r_id;
      r_rsp_data  <= w_sh_result;
      r_rsp_carry <= w_sh_carry;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = (r_state == DONE);
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_carry = r_rsp_carry;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed bench for shifter_arbiter: round-robin DUT plus a fixed-priority DUT on mirrored stimulus.
module tb_shifter_arbiter;
  import shifter_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  shifter_arbiter_if bus ();
  shifter_arbiter_if bus_f ();

  assign bus_f.req_valid = bus.req_valid;
  assign bus_f.req_type  = bus.req_type;
  assign bus_f.req_amt   = bus.req_amt;
  assign bus_f.req_data  = bus.req_data;
  assign bus_f.req_cin   = bus.req_cin;
  assign bus_f.rsp_ready = bus.rsp_ready;

  shifter_arbiter #(.PRIO_FIXED(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  shifter_arbiter #(.PRIO_FIXED(1'b1)) dut_fixed (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          id;
    logic [1:0]  t;
    logic [4:0]  a;
    logic [31:0] d;
    logic        c;
    logic [31:0] ed;
    logic        ec;
  } vec_t;

  // Drives one request, waits for it to be accepted, then returns the response and its latency in edges.
  task automatic send_op(input bit id, input logic [1:0] t, input logic [4:0] a, input logic [31:0] d,
                         input logic c, output int lat, output logic [31:0] rd, output logic rc,
                         output logic rid);
    int n;
    n   = 0;
    lat = -1;
    rd  = '0;
    rc  = 1'b0;
    rid = 1'b0;
    bus.req_type = {~t, ~t};
    bus.req_amt  = {~a, ~a};
    bus.req_data = {~d, ~d};
    bus.req_cin  = {~c, ~c};
    if (id) begin
      bus.req_type[3:2] = t;  bus.req_amt[9:5] = a;  bus.req_data[63:32] = d;  bus.req_cin[1] = c;
    end else begin
      bus.req_type[1:0] = t;  bus.req_amt[4:0] = a;  bus.req_data[31:0] = d;   bus.req_cin[0] = c;
    end
    bus.req_valid     = 2'b00;
    bus.req_valid[id] = 1'b1;
    #1;
    while (!bus.req_ready[id] && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!bus.req_ready[id]) begin
      bus.req_valid = 2'b00;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 2'b00;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    if (!bus.rsp_valid) begin
      lat = -1;
      return;
    end
    rd  = bus.rsp_data;
    rc  = bus.rsp_carry;
    rid = bus.rsp_id;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready: got %b want 00", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if ({bus.rsp_id, bus.rsp_carry, bus.rsp_data} !== 34'd0) begin failures++; $display("FAIL reset_rsp_fields: got id=%b c=%b d=%h want all 0", bus.rsp_id, bus.rsp_carry, bus.rsp_data); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL reset_first_tie: got %b want 01", bus.req_ready); end
    checks++; if (bus_f.req_ready !== 2'b01) begin failures++; $display("FAIL reset_first_tie_fixed: got %b want 01", bus_f.req_ready); end
  endtask

  // Both requesters stay valid from reset; collects the owner of four consecutive responses per DUT.
  task automatic test_round_robin();
    logic [3:0] ids_rr;
    logic [3:0] ids_fx;
    int got;
    int n;
    ids_rr = 4'bxxxx;
    ids_fx = 4'bxxxx;
    got    = 0;
    n      = 0;
    bus.req_type  = {SH_LSL, SH_LSL};
    bus.req_amt   = {5'd1, 5'd2};
    bus.req_data  = {32'h1, 32'h1};
    bus.req_cin   = 2'b00;
    bus.rsp_ready = 1'b1;
    while (got < 4 && n < 60) begin
      @(posedge clk); @(negedge clk); n++;
      if (bus.rsp_valid) begin
        ids_rr[got] = bus.rsp_id;
        ids_fx[got] = bus_f.rsp_id;
        got++;
      end
    end
    bus.req_valid = 2'b00;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    checks++; if (got !== 4) begin failures++; $display("FAIL rr_count: got %0d responses want 4", got); end
    checks++; if (ids_rr !== 4'b1010) begin failures++; $display("FAIL rr_sequence: got %b want 1010 (first id in bit 0)", ids_rr); end
    checks++; if (ids_fx !== 4'b0000) begin failures++; $display("FAIL fixed_sequence: got %b want 0000", ids_fx); end
  endtask

  task automatic test_shift_vectors();
    vec_t        v[11];
    int          lat;
    logic [31:0] rd;
    logic        rc;
    logic        rid;
    v = '{
      '{1'b0, SH_LSL, 5'd4,  32'h0000_00F1, 1'b0, 32'h0000_0F10, 1'b0},
      '{1'b1, SH_LSR, 5'd0,  32'h8000_0001, 1'b0, 32'h0000_0000, 1'b1},
      '{1'b1, SH_ASR, 5'd4,  32'hF000_0008, 1'b0, 32'hFF00_0000, 1'b1},
      '{1'b0, SH_LSL, 5'd0,  32'h0000_1234, 1'b1, 32'h0000_1234, 1'b1},
      '{1'b1, SH_LSL, 5'd31, 32'h0000_0003, 1'b0, 32'h8000_0000, 1'b1},
      '{1'b0, SH_LSR, 5'd1,  32'h0000_0003, 1'b0, 32'h0000_0001, 1'b1},
      '{1'b1, SH_ASR, 5'd0,  32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 1'b0},
      '{1'b0, SH_ROR, 5'd8,  32'h0000_00A5, 1'b0, 32'hA500_0000, 1'b1},
      '{1'b1, SH_LSR, 5'd31, 32'h8000_0000, 1'b0, 32'h0000_0001, 1'b0},
      '{1'b0, SH_ASR, 5'd31, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0},
      '{1'b0, SH_ROR, 5'd1,  32'h0000_0002, 1'b1, 32'h0000_0001, 1'b0}
    };
    for (int i = 0; i < 11; i++) begin
      send_op(v[i].id, v[i].t, v[i].a, v[i].d, v[i].c, lat, rd, rc, rid);
      checks++; if (lat !== 2) begin failures++; $display("FAIL vec%0d_latency: got %0d edges want 2", i, lat); end
      checks++; if (rd !== v[i].ed) begin failures++; $display("FAIL vec%0d_data: got %h want %h", i, rd, v[i].ed); end
      checks++; if (rc !== v[i].ec) begin failures++; $display("FAIL vec%0d_carry: got %b want %b", i, rc, v[i].ec); end
      checks++; if (rid !== v[i].id) begin failures++; $display("FAIL vec%0d_id: got %b want %b", i, rid, v[i].id); end
    end
  endtask

  task automatic test_ror_zero();
    int          lat;
    logic [31:0] rd;
    logic        rc;
    logic        rid;
    logic [31:0] exp_d;
`ifdef SHIFTER_ARB_RRX_EN
    exp_d = 32'h8000_0001;
`else
    exp_d = 32'h0000_0003;
`endif
    send_op(1'b0, SH_ROR, 5'd0, 32'h0000_0003, 1'b1, lat, rd, rc, rid);
    checks++; if (lat !== 2) begin failures++; $display("FAIL ror0_latency: got %0d want 2", lat); end
    checks++; if (rd !== exp_d) begin failures++; $display("FAIL ror0_data: got %h want %h", rd, exp_d); end
    checks++; if (rc !== 1'b1) begin failures++; $display("FAIL ror0_carry: got %b want 1", rc); end
  endtask

  // Requester 1 issues ROR #8; consumer stalls three cycles in DONE while both requesters knock.
  task automatic test_backpressure();
    int n;
    n = 0;
    bus.req_type  = {SH_ROR, SH_LSL};
    bus.req_amt   = {5'd8, 5'd0};
    bus.req_data  = {32'h0000_00A5, 32'h0};
    bus.req_cin   = 2'b00;
    bus.req_valid = 2'b10;
    #1;
    while (!bus.rsp_valid && n < 20) begin
      @(posedge clk); @(negedge clk); n++;
      bus.req_valid = 2'b11;
    end
    checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_reach_done: got rsp_valid=%b want 1", bus.rsp_valid); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_carry, bus.rsp_data} !== {1'b1, 1'b1, 1'b1, 32'hA500_0000})
        begin failures++; $display("FAIL bp_hold%0d: got v=%b id=%b c=%b d=%h want v=1 id=1 c=1 d=a5000000", i, bus.rsp_valid, bus.rsp_id, bus.rsp_carry, bus.rsp_data); end
      checks++; if (bus.req_ready !== 2'b00) begin failures++; $display("FAIL bp_ready%0d: got %b want 00", i, bus.req_ready); end
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL bp_busy%0d: got %b want 1", i, bus.busy); end
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.rsp_ready = 1'b0;
    checks++; if ({bus.busy, bus.rsp_valid} !== 2'b00) begin failures++; $display("FAIL bp_release: got busy=%b rsp_valid=%b want 0 0", bus.busy, bus.rsp_valid); end
  endtask

  task automatic test_reset_in_busy();
    logic seen;
    int   n;
    seen = 1'b0;
    n    = 0;
    bus.req_type  = {SH_LSR, SH_LSL};
    bus.req_amt   = 10'd0;
    bus.req_data  = {32'h8000_0001, 32'h0};
    bus.req_cin   = 2'b00;
    bus.req_valid = 2'b10;
    #1;
    while (!bus.req_ready[1] && n < 20) begin
      @(negedge clk); #1; n++;
    end
    @(posedge clk); @(negedge clk);
    bus.req_valid = 2'b00;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL abort_in_busy: got busy=%b want 1", bus.busy); end
    reset = 1'b0;
    #1;
    checks++; if ({bus.rsp_valid, bus.busy, bus.rsp_id, bus.rsp_carry, bus.rsp_data, bus.req_ready} !== 38'd0)
      begin failures++; $display("FAIL abort_outputs: got v=%b busy=%b id=%b c=%b d=%h rdy=%b want all 0", bus.rsp_valid, bus.busy, bus.rsp_id, bus.rsp_carry, bus.rsp_data, bus.req_ready); end
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      seen = seen | bus.rsp_valid | bus.busy;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_response: got activity=%b want 0", seen); end
    bus.req_valid = 2'b11;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL abort_next_tie: got %b want 01", bus.req_ready); end
    bus.req_valid = 2'b00;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_type  = '0;
    bus.req_amt   = '0;
    bus.req_data  = '0;
    bus.req_cin   = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_round_robin();
    test_shift_vectors();
    test_ror_zero();
    test_backpressure();
    test_reset_in_busy();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
